// File: rtl/inference_epoch_scheduler_pkg.sv
// Shared types and sizing constants for the per-epoch inference sequencer.
package inference_epoch_scheduler_pkg;

  localparam int unsigned MAX_LAYER_DEPTH  = 16;
  localparam int unsigned INPUT_DATA_WIDTH = 16;
  localparam int unsigned SCHED_WINDOW     = 8;
  localparam int unsigned COUNT_WIDTH      = 8;
  localparam int unsigned CLASS_WIDTH      = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    PUSH  = 3'd4
  } sched_state_t;

  typedef struct packed {
    logic [CLASS_WIDTH-1:0] class_idx;
    logic [COUNT_WIDTH-1:0] count;
  } epoch_record_t;

endpackage

// File: rtl/inference_epoch_scheduler_count_window_buffer.sv
// Circular buffer of the most recent epoch counts with a saturating fill counter.
// Reads are addressed by offset from the oldest entry.
module count_window_buffer
  import inference_epoch_scheduler_pkg::*;
#(
  parameter int unsigned WINDOW    = SCHED_WINDOW,
  parameter int unsigned PTR_WIDTH = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [COUNT_WIDTH-1:0] wr_data,
  input  logic                   clear_fill,
  input  logic [PTR_WIDTH-1:0]   rd_offset,
  output logic [COUNT_WIDTH-1:0] rd_data,
  output logic [COUNT_WIDTH-1:0] newest,
  output logic                   full,
  output logic                   full_next_c
);

  localparam int unsigned FILL_WIDTH = $clog2(WINDOW + 1);
  localparam int unsigned SUM_WIDTH  = PTR_WIDTH + 1;

  logic [COUNT_WIDTH-1:0] mem_q [WINDOW];
  logic [PTR_WIDTH-1:0]   wr_ptr_q;
  logic [FILL_WIDTH-1:0]  fill_q;
  logic [FILL_WIDTH-1:0]  fill_d;
  logic [SUM_WIDTH-1:0]   rd_sum;
  logic [PTR_WIDTH-1:0]   rd_idx;
  logic [PTR_WIDTH-1:0]   newest_idx;

  // Enable rise restarts the fill count; a same-cycle write still counts.
  always_comb begin
    fill_d = clear_fill ? '0 : fill_q;
    if (wr_en && (fill_d != FILL_WIDTH'(WINDOW))) begin
      fill_d = fill_d + FILL_WIDTH'(1);
    end
  end

  assign full_next_c = (fill_d == FILL_WIDTH'(WINDOW));

  // Write pointer always sits on the oldest entry, so offset 0 is oldest.
  always_comb begin
    rd_sum = {1'b0, wr_ptr_q} + {1'b0, rd_offset};
    if (rd_sum >= SUM_WIDTH'(WINDOW)) begin
      rd_idx = PTR_WIDTH'(rd_sum - SUM_WIDTH'(WINDOW));
    end else begin
      rd_idx = PTR_WIDTH'(rd_sum);
    end
    newest_idx = (wr_ptr_q == '0) ? PTR_WIDTH'(WINDOW - 1) : (wr_ptr_q - PTR_WIDTH'(1));
  end

  assign rd_data = mem_q[rd_idx];
  assign newest  = mem_q[newest_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      full     <= 1'b0;
      for (int i = 0; i < int'(WINDOW); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      fill_q <= fill_d;
      full   <= full_next_c;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= (wr_ptr_q == PTR_WIDTH'(WINDOW - 1)) ? '0 : (wr_ptr_q + PTR_WIDTH'(1));
      end
    end
  end

endmodule

// File: rtl/inference_epoch_scheduler.sv
// Sequences window load, NN start, result wait and FIFO push for every new
// epoch count once the feature window is full.
module inference_epoch_scheduler
  import inference_epoch_scheduler_pkg::*;
#(
  parameter int unsigned WINDOW         = SCHED_WINDOW,
  parameter int unsigned ADDR_WIDTH     = $clog2(MAX_LAYER_DEPTH),
  parameter int unsigned DATA_WIDTH     = INPUT_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_enable,
  input  logic [7:0]            i_count,
  input  logic                  i_count_valid,
  output logic [ADDR_WIDTH-1:0] o_nn_addr,
  output logic [DATA_WIDTH-1:0] o_nn_data,
  output logic                  o_nn_we,
  output logic                  o_nn_valid,
  output logic                  o_nn_start,
  input  logic                  i_nn_done,
  input  logic [7:0]            i_nn_predicted_class,
  output logic                  o_fifo_input_valid,
  output logic [15:0]           o_fifo_input_data,
  input  logic                  i_fifo_ready_for_input,
  output logic                  o_busy,
  output logic                  o_window_full,
  output logic                  o_dropped,
  output logic                  o_timeout,
  input  logic                  i_clear_flags
);

  localparam int unsigned PTR_WIDTH = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned TO_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [TO_WIDTH-1:0]   tcnt_q, tcnt_d;
  epoch_record_t         rec_q, rec_d;
  logic                  pending_q, pending_d;
  logic                  enable_q;

  logic [ADDR_WIDTH-1:0] nn_addr_q, nn_addr_d;
  logic [DATA_WIDTH-1:0] nn_data_q, nn_data_d;
  logic                  nn_we_q, nn_we_d;
  logic                  nn_start_q, nn_start_d;
  logic                  fifo_valid_q, fifo_valid_d;
  logic                  busy_q, busy_d;
  logic                  dropped_q, dropped_d;
  logic                  timeout_q, timeout_d;

  logic                   enable_rise;
  logic [PTR_WIDTH-1:0]   rd_offset;
  logic [COUNT_WIDTH-1:0] rd_data;
  logic [COUNT_WIDTH-1:0] newest;
  logic                   window_full;
  logic                   full_next_c;

  assign enable_rise = i_enable & ~enable_q;

  // Fetch the word that will be presented on the next cycle.
  assign rd_offset = (state_q == LOAD) ? PTR_WIDTH'(idx_q + ADDR_WIDTH'(1)) : '0;

  count_window_buffer #(
    .WINDOW    (WINDOW),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_window (
    .clk         (clk),
    .rst_n       (reset),
    .wr_en       (i_count_valid),
    .wr_data     (i_count),
    .clear_fill  (enable_rise),
    .rd_offset   (rd_offset),
    .rd_data     (rd_data),
    .newest      (newest),
    .full        (window_full),
    .full_next_c (full_next_c)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tcnt_d       = tcnt_q;
    rec_d        = rec_q;
    pending_d    = pending_q;
    nn_addr_d    = '0;
    nn_data_d    = '0;
    nn_we_d      = 1'b0;
    nn_start_d   = 1'b0;
    fifo_valid_d = 1'b0;
    dropped_d    = dropped_q;
    timeout_d    = timeout_q;

    if (i_clear_flags) begin
      dropped_d = 1'b0;
      timeout_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (pending_q && i_enable) begin
          state_d     = LOAD;
          pending_d   = 1'b0;
          rec_d.count = newest;
          idx_d       = '0;
          nn_we_d     = 1'b1;
          nn_data_d   = DATA_WIDTH'(rd_data);
        end
      end
      LOAD: begin
        if (idx_q == ADDR_WIDTH'(WINDOW - 1)) begin
          state_d    = START;
          nn_start_d = 1'b1;
          tcnt_d     = '0;
        end else begin
          idx_d     = idx_q + ADDR_WIDTH'(1);
          nn_we_d   = 1'b1;
          nn_addr_d = idx_q + ADDR_WIDTH'(1);
          nn_data_d = DATA_WIDTH'(rd_data);
        end
      end
      START: begin
        state_d = WAIT;
        tcnt_d  = tcnt_q + TO_WIDTH'(1);
      end
      WAIT: begin
        // Counter holds cycles elapsed since the start pulse.
        if (i_nn_done) begin
          rec_d.class_idx = i_nn_predicted_class;
          state_d         = PUSH;
          fifo_valid_d    = 1'b1;
        end else if (tcnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tcnt_d = tcnt_q + TO_WIDTH'(1);
        end
      end
      PUSH: begin
        if (i_fifo_ready_for_input) begin
          state_d = IDLE;
        end else begin
          fifo_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new request overrides the launch-time clear; extra requests collapse.
    if (i_count_valid) begin
      if (pending_q && (state_q != IDLE)) begin
        dropped_d = 1'b1;
      end
      if (i_enable && full_next_c) begin
        pending_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      tcnt_q       <= '0;
      rec_q        <= '0;
      pending_q    <= 1'b0;
      enable_q     <= 1'b0;
      nn_addr_q    <= '0;
      nn_data_q    <= '0;
      nn_we_q      <= 1'b0;
      nn_start_q   <= 1'b0;
      fifo_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      dropped_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tcnt_q       <= tcnt_d;
      rec_q        <= rec_d;
      pending_q    <= pending_d;
      enable_q     <= i_enable;
      nn_addr_q    <= nn_addr_d;
      nn_data_q    <= nn_data_d;
      nn_we_q      <= nn_we_d;
      nn_start_q   <= nn_start_d;
      fifo_valid_q <= fifo_valid_d;
      busy_q       <= busy_d;
      dropped_q    <= dropped_d;
      timeout_q    <= timeout_d;
    end
  end

  assign o_nn_addr          = nn_addr_q;
  assign o_nn_data          = nn_data_q;
  assign o_nn_we            = nn_we_q;
  assign o_nn_valid         = nn_we_q;
  assign o_nn_start         = nn_start_q;
  assign o_fifo_input_valid = fifo_valid_q;
  assign o_fifo_input_data  = rec_q;
  assign o_busy             = busy_q;
  assign o_window_full      = window_full;
  assign o_dropped          = dropped_q;
  assign o_timeout          = timeout_q;

endmodule

// File: tb/tb_inference_epoch_scheduler.sv
// Scenario bench for inference_epoch_scheduler against a queue-based window model.
module tb_inference_epoch_scheduler;

  localparam int unsigned W  = 4;
  localparam int unsigned TO = 100;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_enable = 1'b0;
  logic [7:0]    i_count = '0;
  logic          i_count_valid = 1'b0;
  logic [AW-1:0] o_nn_addr;
  logic [DW-1:0] o_nn_data;
  logic          o_nn_we, o_nn_valid, o_nn_start;
  logic          i_nn_done = 1'b0;
  logic [7:0]    i_nn_predicted_class = '0;
  logic          o_fifo_input_valid;
  logic [15:0]   o_fifo_input_data;
  logic          i_fifo_ready_for_input = 1'b0;
  logic          o_busy, o_window_full, o_dropped, o_timeout;
  logic          i_clear_flags = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int start_cnt = 0;
  int starts_expected = 0;
  int exp_count = 0;

  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];
  logic          wr_valid_q [$];
  logic [15:0]   fifo_q [$];
  int            mwin [$];
  int            mfill = 0;

  always #5 clk = ~clk;

  inference_epoch_scheduler #(
    .WINDOW         (W),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                    (clk),
    .reset                  (rst_n),
    .i_enable               (i_enable),
    .i_count                (i_count),
    .i_count_valid          (i_count_valid),
    .o_nn_addr              (o_nn_addr),
    .o_nn_data              (o_nn_data),
    .o_nn_we                (o_nn_we),
    .o_nn_valid             (o_nn_valid),
    .o_nn_start             (o_nn_start),
    .i_nn_done              (i_nn_done),
    .i_nn_predicted_class   (i_nn_predicted_class),
    .o_fifo_input_valid     (o_fifo_input_valid),
    .o_fifo_input_data      (o_fifo_input_data),
    .i_fifo_ready_for_input (i_fifo_ready_for_input),
    .o_busy                 (o_busy),
    .o_window_full          (o_window_full),
    .o_dropped              (o_dropped),
    .o_timeout              (o_timeout),
    .i_clear_flags          (i_clear_flags)
  );

  // Log NN writes, start pulses and FIFO transfers mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_nn_we) begin
        wr_addr_q.push_back(o_nn_addr);
        wr_data_q.push_back(o_nn_data);
        wr_valid_q.push_back(o_nn_valid);
      end
      if (o_nn_start) start_cnt++;
      if (o_fifo_input_valid && i_fifo_ready_for_input) fifo_q.push_back(o_fifo_input_data);
    end
  end

  function automatic logic [43:0] all_outs();
    return {o_nn_addr, o_nn_data, o_nn_we, o_nn_valid, o_nn_start, o_fifo_input_valid,
            o_fifo_input_data, o_busy, o_window_full, o_dropped, o_timeout};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic model_reset();
    mwin = {0, 0, 0, 0};
    mfill = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_valid_q.delete();
    fifo_q.delete();
  endtask

  task automatic strobe(input int c);
    i_count = 8'(c);
    i_count_valid = 1'b1;
    mwin.push_back(c);
    void'(mwin.pop_front());
    if (mfill < int'(W)) mfill++;
    cyc(1);
    i_count_valid = 1'b0;
    vectors++;
    if (o_window_full !== (mfill == int'(W))) begin
      miscompares++;
      $display("FAIL window_full after count %0d: got %b want %b", c, o_window_full, mfill == int'(W));
    end
  endtask

  // Wait for the start pulse, then check the words loaded before it.
  task automatic wait_load_start();
    int n = 0;
    while (o_nn_start !== 1'b1 && n < 64) begin
      cyc(1);
      n++;
    end
    vectors++;
    if (o_nn_start !== 1'b1) begin
      miscompares++;
      $display("FAIL start_pulse: got %b want 1 within 64 cycles", o_nn_start);
      return;
    end
    starts_expected++;
    exp_count = mwin[W-1];
    vectors++;
    if (wr_data_q.size() != int'(W)) begin
      miscompares++;
      $display("FAIL load_len: got %0d words want %0d", wr_data_q.size(), W);
    end
    for (int i = 0; i < int'(W); i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          v;
      if (wr_data_q.size() == 0) break;
      a = wr_addr_q.pop_front();
      d = wr_data_q.pop_front();
      v = wr_valid_q.pop_front();
      vectors++;
      if (a !== AW'(i) || d !== DW'(mwin[i]) || v !== 1'b1) begin
        miscompares++;
        $display("FAIL load_word%0d: got addr %0d data %0d valid %b want addr %0d data %0d valid 1",
                 i, a, d, v, i, mwin[i]);
      end
    end
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_valid_q.delete();
  endtask

  // Return done after 'delay' WAIT cycles, optionally hold FIFO not-ready.
  task automatic finish_inference(input int cls, input int delay, input int hold);
    logic [15:0] exp_rec;
    logic [15:0] got;
    bit ok;
    exp_rec = {8'(cls), 8'(exp_count)};
    cyc(1 + delay);
    if (hold > 0) i_fifo_ready_for_input = 1'b0;
    i_nn_done = 1'b1;
    i_nn_predicted_class = 8'(cls);
    cyc(1);
    i_nn_done = 1'b0;
    i_nn_predicted_class = 8'($urandom);
    vectors++;
    if (o_fifo_input_valid !== 1'b1 || o_fifo_input_data !== exp_rec) begin
      miscompares++;
      $display("FAIL record: got valid %b data %h want valid 1 data %h",
               o_fifo_input_valid, o_fifo_input_data, exp_rec);
    end
    if (hold > 0) begin
      ok = 1'b1;
      repeat (hold) begin
        cyc(1);
        if (o_fifo_input_valid !== 1'b1 || o_fifo_input_data !== exp_rec) ok = 1'b0;
      end
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL backpressure_hold: got valid %b data %h want valid 1 data %h",
                 o_fifo_input_valid, o_fifo_input_data, exp_rec);
      end
      i_fifo_ready_for_input = 1'b1;
    end
    cyc(1);
    vectors++;
    if (fifo_q.size() != 1) begin
      miscompares++;
      $display("FAIL fifo_transfers: got %0d want 1", fifo_q.size());
    end else begin
      got = fifo_q.pop_front();
      vectors++;
      if (got !== exp_rec) begin
        miscompares++;
        $display("FAIL fifo_word: got %h want %h", got, exp_rec);
      end
    end
    fifo_q.delete();
    vectors++;
    if (o_fifo_input_valid !== 1'b0 || start_cnt != starts_expected) begin
      miscompares++;
      $display("FAIL after_push: got valid %b starts %0d want valid 0 starts %0d",
               o_fifo_input_valid, start_cnt, starts_expected);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    vectors++;
    if (all_outs() !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", all_outs());
    end
    rst_n = 1'b1;
    i_enable = 1'b1;
    i_fifo_ready_for_input = 1'b1;
    model_reset();
    cyc(2);
  endtask

  task automatic test_first_window();
    strobe(10); cyc(2);
    strobe(20); cyc(1);
    strobe(30); cyc(5);
    vectors++;
    if (wr_data_q.size() != 0 || start_cnt != 0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL early_activity: got writes %0d starts %0d busy %b want 0 0 0",
               wr_data_q.size(), start_cnt, o_busy);
    end
    strobe(40);
    vectors++;
    if (o_nn_we !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early: got we %b want 0", o_nn_we);
    end
    cyc(1);
    vectors++;
    if (o_nn_we !== 1'b1 || o_nn_valid !== 1'b1 || o_nn_addr !== '0 || o_nn_data !== DW'(10)) begin
      miscompares++;
      $display("FAIL latency_first_word: got we %b valid %b addr %0d data %0d want 1 1 0 10",
               o_nn_we, o_nn_valid, o_nn_addr, o_nn_data);
    end
    wait_load_start();
    finish_inference(2, 0, 0);
  endtask

  task automatic test_slide();
    strobe(50);
    wait_load_start();
    finish_inference(1, 2, 0);
  endtask

  task automatic test_back_to_back();
    strobe(55);
    wait_load_start();
    cyc(2);
    strobe(60);
    vectors++;
    if (o_dropped !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_first: got %b want 0", o_dropped);
    end
    cyc(1);
    strobe(70);
    vectors++;
    if (o_dropped !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_second: got %b want 1", o_dropped);
    end
    exp_count = 55;
    finish_inference(3, 0, 0);
    wait_load_start();
    finish_inference(4, 1, 0);
    cyc(20);
    vectors++;
    if (start_cnt != starts_expected || fifo_q.size() != 0 || o_busy !== 1'b0 || o_dropped !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_single_rerun: got starts %0d fifo %0d busy %b dropped %b want %0d 0 0 1",
               start_cnt, fifo_q.size(), o_busy, o_dropped, starts_expected);
    end
    i_clear_flags = 1'b1;
    cyc(1);
    i_clear_flags = 1'b0;
    vectors++;
    if (o_dropped !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_clear: got %b want 0", o_dropped);
    end
  endtask

  task automatic test_backpressure();
    strobe(int'($urandom_range(0, 255)));
    wait_load_start();
    finish_inference(int'($urandom_range(0, 255)), 0, 20);
  endtask

  task automatic test_timeout();
    int n = 0;
    bit quiet = 1'b1;
    strobe(int'($urandom_range(0, 255)));
    wait_load_start();
    while (o_timeout !== 1'b1 && n < 300) begin
      cyc(1);
      n++;
      if (o_fifo_input_valid !== 1'b0) quiet = 1'b0;
    end
    vectors++;
    if (n != int'(TO)) begin
      miscompares++;
      $display("FAIL timeout_cycles: got %0d want %0d", n, TO);
    end
    vectors++;
    if (o_busy !== 1'b0 || !quiet || fifo_q.size() != 0) begin
      miscompares++;
      $display("FAIL timeout_state: got busy %b quiet %b fifo %0d want 0 1 0", o_busy, quiet, fifo_q.size());
    end
    i_nn_done = 1'b1;
    i_nn_predicted_class = 8'd9;
    cyc(1);
    i_nn_done = 1'b0;
    cyc(2);
    vectors++;
    if (o_fifo_input_valid !== 1'b0 || o_busy !== 1'b0 || o_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL stray_done: got valid %b busy %b timeout %b want 0 0 1",
               o_fifo_input_valid, o_busy, o_timeout);
    end
    i_clear_flags = 1'b1;
    cyc(1);
    i_clear_flags = 1'b0;
    vectors++;
    if (o_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_clear: got %b want 0", o_timeout);
    end
  endtask

  task automatic test_random();
    repeat (8) begin
      cyc(int'($urandom_range(0, 3)));
      strobe(int'($urandom_range(0, 255)));
      wait_load_start();
      finish_inference(int'($urandom_range(0, 255)), int'($urandom_range(0, 6)),
                       ($urandom_range(0, 1) == 1) ? 3 : 0);
    end
  endtask

  task automatic test_reset_during_load();
    strobe(int'($urandom_range(0, 255)));
    cyc(1);
    vectors++;
    if (o_nn_we !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_load: got we %b want 1", o_nn_we);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (all_outs() !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got %h want 0", all_outs());
    end
    cyc(2);
    rst_n = 1'b1;
    model_reset();
    cyc(1);
    vectors++;
    if (o_window_full !== 1'b0) begin
      miscompares++;
      $display("FAIL full_after_reset: got %b want 0", o_window_full);
    end
    for (int i = 0; i < int'(W) - 1; i++) strobe(int'($urandom_range(0, 255)));
    cyc(5);
    vectors++;
    if (start_cnt != starts_expected || o_busy !== 1'b0 || wr_data_q.size() != 0) begin
      miscompares++;
      $display("FAIL refill_early: got starts %0d busy %b writes %0d want %0d 0 0",
               start_cnt, o_busy, wr_data_q.size(), starts_expected);
    end
    strobe(int'($urandom_range(0, 255)));
    wait_load_start();
    finish_inference(int'($urandom_range(0, 255)), 0, 0);
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_slide();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_random();
    test_reset_during_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
